// File: rtl/filtros_pkg.sv
// Shared types and helpers for the image-filter accumulation blocks.
package filtros_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  localparam int DEF_PIX_W = 8;

  // Group-sum width: one extra bit per doubling of the group size.
  function automatic int sum_w(input int pix_w, input int win_log2);
    return pix_w + win_log2;
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Combinational unsigned adder: running accumulator plus a zero-extended pixel.
module acc_adder #(
  parameter int A_W = 10,
  parameter int B_W = 8
) (
  input  logic [A_W-1:0] acc,
  input  logic [B_W-1:0] pix,
  output logic [A_W-1:0] sum
);

  assign sum = acc + {{(A_W-B_W){1'b0}}, pix};

endmodule

// File: rtl/pixel_avg_accum.sv
// Streaming pixel accumulator: sums groups of 2**WIN_LOG2 pixels, emits sum and average.
// Define PIX_AVG_ROUND_EN for round-half-up averaging; truncation otherwise.
module pixel_avg_accum
  import filtros_pkg::*;
#(
  parameter int PIX_W    = DEF_PIX_W,
  parameter int WIN_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W-1:0]          in_pix,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PIX_W+WIN_LOG2-1:0] out_sum,
  output logic [PIX_W-1:0]          out_avg
);

  localparam int SUM_W = sum_w(PIX_W, WIN_LOG2);
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
  localparam logic [WIN_LOG2-1:0] CNT_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  acc_state_t          state;
  logic [SUM_W-1:0]    acc;
  logic [WIN_LOG2-1:0] cnt;
  logic [SUM_W-1:0]    sum_next;
  logic [PIX_W-1:0]    avg_next;

  acc_adder #(
    .A_W(SUM_W),
    .B_W(PIX_W)
  ) u_adder (
    .acc(acc),
    .pix(in_pix),
    .sum(sum_next)
  );

  // Adding 2**(WIN_LOG2-1) before the shift equals adding the bit just below the cut.
`ifdef PIX_AVG_ROUND_EN
  assign avg_next = sum_next[SUM_W-1:WIN_LOG2]
                  + {{(PIX_W-1){1'b0}}, sum_next[WIN_LOG2-1]};
`else
  assign avg_next = sum_next[SUM_W-1:WIN_LOG2];
`endif

  assign in_ready = (state == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
    end else if (clear) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= sum_next;
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state     <= HOLD;
              out_sum   <= sum_next;
              out_avg   <= avg_next;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_avg_accum.sv
// Scoreboard bench for pixel_avg_accum: directed groups, clear/reset cases, then random traffic.
module tb_pixel_avg_accum;
  localparam int PIX_W = 8;
  localparam int WIN_LOG2 = 2;
  localparam int K = 1 << WIN_LOG2;
  localparam int SUM_W = PIX_W + WIN_LOG2;

  logic clk = 1'b0;
  logic rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [PIX_W-1:0] in_pix;
  logic [SUM_W-1:0] out_sum;
  logic [PIX_W-1:0] out_avg;

  pixel_avg_accum #(.PIX_W(PIX_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_avg(out_avg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int avg;
  } result_t;

  result_t sb[$];
  int grp[$];
  bit hold;
  int checks = 0;
  int passes = 0;
  int results_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic result_t group_result(input int pix[$]);
    result_t r;
    r.sum = 0;
    foreach (pix[i]) r.sum += pix[i];
`ifdef PIX_AVG_ROUND_EN
    r.avg = (r.sum + K / 2) / K;
`else
    r.avg = r.sum / K;
`endif
    return r;
  endfunction

  // One clock of stimulus; the model then advances by the same edge and is checked.
  task automatic cyc(input bit v, input int p, input bit ordy, input bit clr);
    result_t r;
    in_valid = v; in_pix = PIX_W'(p); out_ready = ordy; clear = clr;
    @(posedge clk); #1;
    if (clr) begin
      grp.delete(); sb.delete(); hold = 0;
    end else if (hold) begin
      if (ordy) hold = 0;
    end else if (v) begin
      grp.push_back(p);
      if (grp.size() == K) begin
        r = group_result(grp);
        sb.push_back(r);
        $display("group done: sum=%0d avg=%0d", r.sum, r.avg);
        grp.delete();
        hold = 1;
      end
    end
    check("in_ready", int'(in_ready), int'(!hold));
    check("out_valid", int'(out_valid), int'(hold));
  endtask

  task automatic rst_pulse();
    in_valid = 0; clear = 0;
    rst = 1; #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_avg", int'(out_avg), 0);
    rst = 0;
    grp.delete(); sb.delete(); hold = 0;
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d);
    cyc(1, a, 1, 0); cyc(1, b, 1, 0); cyc(1, c, 1, 0); cyc(1, d, 1, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_sum", int'(out_sum), sb[0].sum);
        check("out_avg", int'(out_avg), sb[0].avg);
        if (out_ready && !clear) begin
          $display("result: sum=%0d avg=%0d", out_sum, out_avg);
          void'(sb.pop_front());
          results_seen++;
        end
      end
    end
  end

  initial begin
    rst = 1; clear = 0; in_valid = 0; out_ready = 0; in_pix = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); in_pix = PIX_W'($urandom);
      clear = 1'($urandom);
      @(posedge clk); #1;
      check("init_out_valid", int'(out_valid), 0);
      check("init_out_sum", int'(out_sum), 0);
      check("init_out_avg", int'(out_avg), 0);
    end
    rst = 0; in_valid = 0; clear = 0;
    hold = 0;

    send_group(10, 20, 30, 40);
    cyc(0, 0, 1, 0);
    send_group(255, 255, 255, 255);
    cyc(0, 0, 1, 0);
    send_group(1, 1, 2, 2);
    cyc(0, 0, 1, 0);

    // Backpressure: result held for 6 cycles while in_valid stays high.
    cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 99, 0, 0);
    cyc(1, 99, 1, 0);
    send_group(8, 8, 8, 8);
    cyc(0, 0, 1, 0);

    // Clear after a partial group, then a clean group.
    cyc(1, 50, 1, 0); cyc(1, 60, 1, 0);
    cyc(1, 77, 1, 1);
    send_group(8, 8, 8, 8);
    cyc(0, 0, 1, 0);

    // Reset pulse after three samples, then a clean group.
    cyc(1, 50, 1, 0); cyc(1, 60, 1, 0); cyc(1, 70, 1, 0);
    rst_pulse();
    send_group(8, 8, 8, 8);
    cyc(0, 0, 1, 0);

    // Clear while a result is pending.
    send_group(3, 4, 5, 6);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      int p;
      p = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) rst_pulse();
      else cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 9) < 7,
               $urandom_range(0, 49) == 0);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    check("results_seen_min", int'(results_seen >= 100), 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
